// File: rtl/vga_fb_scheduler_if.sv
// Bus bundle between the framebuffer scheduler, the CPU request port and
// the single-port framebuffer SRAM.
//
// Handshake (CPU request side): a request transfers on a rising clk edge
// where cpu_req_valid && cpu_req_ready are both 1. The requester must hold
// cpu_req_we/addr/wdata stable while cpu_req_valid=1 and ready=0. A read
// that transfers yields cpu_resp_valid=1 for exactly one cycle on the next
// cycle. There is no backpressure on the response. Writes produce no
// response.
//
// SRAM side: mem_en/mem_we/mem_addr/mem_wdata are sampled by the SRAM on
// the rising clk edge. mem_rdata is valid in the cycle after a read.
//
// Modports:
//   slave  - the scheduler. It accepts CPU requests and drives the SRAM.
//   master - the environment. It issues CPU requests and models the SRAM.
interface vga_fb_scheduler_if #(
   parameter int ADDR_W = 17
);
   logic              cpu_req_valid;
   logic              cpu_req_ready;
   logic              cpu_req_we;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic [31:0]       cpu_req_wdata;
   logic              cpu_resp_valid;
   logic [31:0]       cpu_resp_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_rdata,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_rdata,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vga_fb_scheduler.sv
// Raster timing generator and framebuffer fetch scheduler.
//
// The module scans a frame of H_TOTAL x V_TOTAL clocks. It reads one pixel
// word from the shared SRAM per active clock. It presents vs/hs/de and the
// RGB colour one clock later, which matches the SRAM read latency.
// CPU requests use the SRAM in any clock that has no display fetch.
//
// Ports:
//   clk, rst     - clock and asynchronous active-low reset
//   en           - scan enable. When low, the counters clear and the CPU owns the SRAM.
//   bus          - CPU request/response and SRAM port (vga_fb_scheduler_if.slave)
//   vs_o, hs_o   - sync pulses, active-high, registered
//   de_o         - data enable, registered
//   data_*_o     - pixel colour. It is 0 whenever de_o is 0.
//   frame_done   - one-clock pulse that coincides with the last active pixel
module vga_fb_scheduler #(
   parameter int H_ACTIVE = 400,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 48,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 300,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 13,
   parameter int ADDR_W   = 17
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   vga_fb_scheduler_if.slave   bus,
   output logic                vs_o,
   output logic                hs_o,
   output logic                de_o,
   output logic [7:0]          data_r_o,
   output logic [7:0]          data_g_o,
   output logic [7:0]          data_b_o,
   output logic                frame_done
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int NPIX    = H_ACTIVE * V_ACTIVE;
   // One extra bit so that bounds equal to the total still fit.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_ACT_C      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST_C = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG_C     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END_C     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST_C = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG_C     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END_C     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C     = VW'(V_TOTAL - 1);
   localparam logic [ADDR_W:0] NPIX_C     = (ADDR_W + 1)'(NPIX);

   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic [ADDR_W-1:0] p_addr;

   logic              active;
   logic              hs_n;
   logic              vs_n;
   logic              fetch;
   logic              frame_start;
   logic [ADDR_W-1:0] fetch_addr;
   logic              cpu_acc;
   logic              cpu_in_range;
   logic              resp_in_range;

   // Stage 0: raster decode on the current counter position.
   always_comb begin
      active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hs_n        = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
      vs_n        = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
      fetch       = en && active;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
      // Forcing address 0 at the frame origin removes any dependence on a
      // leftover pixel count from the previous frame.
      fetch_addr  = frame_start ? '0 : p_addr;
   end

   // Raster counters and the display fetch pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         p_addr <= '0;
      end else if (!en) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         p_addr <= '0;
      end else begin
         if (h_cnt == H_LAST_C) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         if (fetch) begin
            p_addr <= fetch_addr + 1'b1;
         end
      end
   end

   // Arbitration: the display fetch always owns the SRAM.
   // An out-of-range CPU request is still accepted, but it never reaches the SRAM.
   // Gating with rst prevents any SRAM access while the block is in reset.
   always_comb begin
      bus.cpu_req_ready = !fetch;
      cpu_acc           = bus.cpu_req_valid && !fetch;
      cpu_in_range      = {1'b0, bus.cpu_req_addr} < NPIX_C;
      bus.mem_en        = rst && (fetch || (cpu_acc && cpu_in_range));
      bus.mem_we        = rst && !fetch && cpu_acc && cpu_in_range && bus.cpu_req_we;
      bus.mem_addr      = fetch ? fetch_addr : bus.cpu_req_addr;
      bus.mem_wdata     = bus.cpu_req_wdata;
   end

   // Stage 1: registered timing, aligned with the SRAM read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_o               <= 1'b0;
         hs_o               <= 1'b0;
         de_o               <= 1'b0;
         frame_done         <= 1'b0;
         bus.cpu_resp_valid <= 1'b0;
         resp_in_range      <= 1'b0;
      end else begin
         vs_o               <= vs_n;
         hs_o               <= hs_n;
         de_o               <= fetch;
         frame_done         <= fetch && (h_cnt == H_ACT_LAST_C) && (v_cnt == V_ACT_LAST_C);
         bus.cpu_resp_valid <= cpu_acc && !bus.cpu_req_we;
         resp_in_range      <= cpu_in_range;
      end
   end

   // The read data arrives one clock after the access. It is masked with the
   // registered qualifiers so that stale SRAM output never leaks out.
   always_comb begin
      {data_r_o, data_g_o, data_b_o} = de_o ? bus.mem_rdata[23:0] : 24'd0;
      bus.cpu_resp_rdata = (bus.cpu_resp_valid && resp_in_range) ? bus.mem_rdata : 32'd0;
   end
endmodule

// File: tb/tb_vga_fb_scheduler.sv
module tb_vga_fb_scheduler;
   // A shrunken raster keeps whole frames short: 15 x 8 clocks, 32 pixels.
   localparam int H_A = 8;
   localparam int H_F = 2;
   localparam int H_S = 3;
   localparam int H_B = 2;
   localparam int V_A = 4;
   localparam int V_F = 1;
   localparam int V_S = 2;
   localparam int V_B = 1;
   localparam int AW  = 6;
   localparam int H_T = H_A + H_F + H_S + H_B;
   localparam int V_T = V_A + V_F + V_S + V_B;
   localparam int NPX = H_A * V_A;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   always #5 clk = ~clk;

   logic       vs_o, hs_o, de_o, frame_done;
   logic [7:0] data_r_o, data_g_o, data_b_o;

   vga_fb_scheduler_if #(.ADDR_W(AW)) bus ();

   vga_fb_scheduler #(
      .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
      .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
      .ADDR_W(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .bus(bus),
      .vs_o(vs_o),
      .hs_o(hs_o),
      .de_o(de_o),
      .data_r_o(data_r_o),
      .data_g_o(data_g_o),
      .data_b_o(data_b_o),
      .frame_done(frame_done)
   );

   // ---------------- expected values ----------------
   int checks = 0;
   int errors = 0;
   logic [23:0] pix_q[$];
   logic [31:0] resp_q[$];

   function automatic logic [23:0] pix_val(input int k, input bit upd);
      logic [7:0] kb;
      kb = 8'(k);
      if (upd && k == 5) return 24'hAABBCC;
      return {kb, kb ^ 8'hC3, 8'hFF - kb};
   endfunction

   function automatic logic [31:0] tim_exp(input int p);
      int h, v;
      h = p % H_T;
      v = (p / H_T) % V_T;
      return {28'd0, (v >= V_A + V_F) && (v < V_A + V_F + V_S),
                     (h >= H_A + H_F) && (h < H_A + H_F + H_S),
                     (h < H_A) && (v < V_A),
                     (h == H_A - 1) && (v == V_A - 1)};
   endfunction

   function automatic bit act_at(input int p);
      return ((p % H_T) < H_A) && (((p / H_T) % V_T) < V_A);
   endfunction

   function automatic int pix_idx(input int p);
      return ((p / H_T) % V_T) * H_A + (p % H_T);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int n, input bit upd);
      for (int k = 0; k < n; k++) pix_q.push_back(pix_val(k, upd));
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- SRAM model ----------------
   logic [31:0] sram [0:63];
   initial begin
      for (int k = 0; k < 64; k++) sram[k] = {8'h5A, pix_val(k, 1'b0)};
      forever begin
         @(posedge clk);
         if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) sram[bus.mem_addr] <= bus.mem_wdata;
            else                     bus.mem_rdata      <= sram[bus.mem_addr];
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (de_o === 1'b1) begin
         if (pix_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected act=0x%0h exp=none t=%0t", {data_r_o, data_g_o, data_b_o}, $time);
         end else begin
            chk("pix", {8'd0, data_r_o, data_g_o, data_b_o}, {8'd0, pix_q.pop_front()});
         end
      end else begin
         chk("pix_blank", {8'd0, data_r_o, data_g_o, data_b_o}, 32'd0);
      end
      if (bus.cpu_resp_valid === 1'b1) begin
         if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected act=0x%0h exp=none t=%0t", bus.cpu_resp_rdata, $time);
         end else begin
            chk("resp", bus.cpu_resp_rdata, resp_q.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int waited;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_we    = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_wdata = '0;
      push_frame(NPX, 1'b0);
      push_frame(NPX, 1'b0);
      push_frame(NPX, 1'b0);

      // Reset state
      adv(3);
      chk("rst_de", 32'(de_o), 32'd0);
      chk("rst_hs", 32'(hs_o), 32'd0);
      chk("rst_vs", 32'(vs_o), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_resp_v", 32'(bus.cpu_resp_valid), 32'd0);
      chk("rst_resp_d", bus.cpu_resp_rdata, 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_ready", 32'(bus.cpu_req_ready), 32'd1);
      rst = 1'b1;
      adv(1);
      chk("idle_mem_en", 32'(bus.mem_en), 32'd0);

      // Two full frames: timing, fetch addresses, frame_done, restart at address 0
      @(posedge clk);
      #1 en = 1'b1;
      @(negedge clk);
      chk("first_fetch_en", 32'(bus.mem_en), 32'd1);
      chk("first_fetch_addr", 32'(bus.mem_addr), 32'd0);
      chk("first_ready", 32'(bus.cpu_req_ready), 32'd0);
      for (int i = 0; i < 2 * H_T * V_T; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("timing", {28'd0, vs_o, hs_o, de_o, frame_done}, tim_exp(i));
         chk("ready", 32'(bus.cpu_req_ready), 32'(!act_at(i + 1)));
         if (act_at(i + 1)) chk("fetch_addr", 32'(bus.mem_addr), 32'(pix_idx(i + 1)));
      end

      // CPU write at h=2 of the line stalls until h=H_A
      adv(2);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_we    = 1'b1;
      bus.cpu_req_addr  = 6'd5;
      bus.cpu_req_wdata = 32'h00AABBCC;
      #1 chk("wr_blocked", 32'(bus.cpu_req_ready), 32'd0);
      waited = 0;
      while (bus.cpu_req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("wr_wait", 32'(waited), 32'd6);
      chk("wr_mem_en", 32'(bus.mem_en), 32'd1);
      chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'd5);
      chk("wr_mem_wdata", bus.mem_wdata, 32'h00AABBCC);
      @(negedge clk);
      chk("sram_wr", sram[5], 32'h00AABBCC);
      push_frame(20, 1'b1);

      // CPU reads in blanking: in range, then out of range
      bus.cpu_req_we   = 1'b0;
      bus.cpu_req_addr = 6'd7;
      #1;
      chk("rd_ready", 32'(bus.cpu_req_ready), 32'd1);
      chk("rd_mem_en", 32'(bus.mem_en), 32'd1);
      chk("rd_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rd_mem_addr", 32'(bus.mem_addr), 32'd7);
      resp_q.push_back(32'h5A07C4F8);
      @(negedge clk);
      bus.cpu_req_addr = 6'd32;
      #1;
      chk("oor_mem_en", 32'(bus.mem_en), 32'd0);
      chk("oor_ready", 32'(bus.cpu_req_ready), 32'd1);
      resp_q.push_back(32'd0);
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;

      // Drop en mid-line at (4,2) of the next frame
      adv(143);
      en = 1'b0;
      #1;
      chk("dis_ready", 32'(bus.cpu_req_ready), 32'd1);
      chk("dis_mem_en", 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      chk("dis_de", 32'(de_o), 32'd0);
      chk("dis_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      chk("dis_sync", {30'd0, hs_o, vs_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("dis_ready_hold", 32'(bus.cpu_req_ready), 32'd1);
         chk("dis_mem_en_hold", 32'(bus.mem_en), 32'd0);
      end

      // Re-enable starts at address 0
      push_frame(8, 1'b1);
      en = 1'b1;
      #1;
      chk("reen_mem_en", 32'(bus.mem_en), 32'd1);
      chk("reen_addr", 32'(bus.mem_addr), 32'd0);
      chk("reen_ready", 32'(bus.cpu_req_ready), 32'd0);

      // Reset during a pending read response, in the hsync region
      adv(11);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_we    = 1'b0;
      bus.cpu_req_addr  = 6'd7;
      #1 chk("prst_ready", 32'(bus.cpu_req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("prst_hs", 32'(hs_o), 32'd1);
      chk("prst_resp_v", 32'(bus.cpu_resp_valid), 32'd1);
      #1;
      rst = 1'b0;
      bus.cpu_req_valid = 1'b0;
      #1;
      chk("mrst_outs", {28'd0, vs_o, hs_o, de_o, frame_done}, 32'd0);
      chk("mrst_resp_v", 32'(bus.cpu_resp_valid), 32'd0);
      chk("mrst_resp_d", bus.cpu_resp_rdata, 32'd0);
      chk("mrst_colour", {8'd0, data_r_o, data_g_o, data_b_o}, 32'd0);
      chk("mrst_mem_en", 32'(bus.mem_en), 32'd0);
      adv(2);
      #1 chk("mrst_mem_en_hold", 32'(bus.mem_en), 32'd0);

      // Release: timing restarts at (0,0); the written pixel persists
      push_frame(NPX, 1'b1);
      rst = 1'b1;
      #1;
      chk("rel_mem_en", 32'(bus.mem_en), 32'd1);
      chk("rel_addr", 32'(bus.mem_addr), 32'd0);
      adv(70);

      chk("pix_q_empty", 32'(pix_q.size()), 32'd0);
      chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Drives the virtual-screen sink (vs/hs/de plus 8-bit R/G/B). Generates raster timing and fetches pixels from a single-port framebuffer SRAM.
- Shares that SRAM with a CPU-side request port. Display reads have absolute priority; CPU accesses proceed in any cycle without a display fetch.
- Sits between the bus bridge / framebuffer RAM and the VGA output or screen model.

Parameters:
H_ACTIVE, 400, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 48, hsync pulse width
H_BP, 64, horizontal back porch
V_ACTIVE, 300, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BP, 13, vertical back porch
ADDR_W, 17, framebuffer word address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
en  in  1  scan enable
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  CPU request accepted this cycle when valid&ready
cpu_req_we  in  1  1=write, 0=read
cpu_req_addr  in  ADDR_W  pixel word address
cpu_req_wdata  in  32  write data {8'd0,R,G,B}
cpu_resp_valid  out  1  read data valid
cpu_resp_rdata  out  32  read data
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid the cycle after mem_en&!mem_we
vs_o  out  1  vsync, active-high
hs_o  out  1  hsync, active-high
de_o  out  1  data enable
data_r_o, data_g_o, data_b_o  out  8 each  pixel colour
frame_done  out  1  one-cycle pulse with the last active pixel of a frame

Behaviour:
- Reset (rst=0, async): h_cnt, v_cnt, p_addr = 0. All registered outputs = 0: vs_o, hs_o, de_o, colour, frame_done, cpu_resp_valid, cpu_resp_rdata.
- Counters:
  - H_TOTAL = sum of the H_* parameters (528); V_TOTAL = sum of the V_* parameters (320).
  - h_cnt counts 0..H_TOTAL-1 and wraps. On wrap, v_cnt increments, wrapping at V_TOTAL-1 -> 0.
  - Counters advance only while en=1.
- Stage 0 (combinational on counters):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs_n = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_n = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Display fetch, when en&&active:
  - Drive mem_en=1, mem_we=0, mem_addr=p_addr.
  - p_addr increments after each fetch. It resets to 0 when h_cnt==0&&v_cnt==0; the next frame therefore always starts at address 0, independent of the previous count.
- Stage 1 (registered, 1-cycle latency):
  - vs_o, hs_o, de_o are the registered vs_n, hs_n, en&&active.
  - While de_o=1, colour = mem_rdata[23:16]/[15:8]/[7:0]; otherwise colour = 0.
  - Result: de_o and colour align exactly, with no bubble.
- Arbitration:
  - cpu_req_ready = !(en&&active), combinational.
  - On accept, drive mem_en=1, mem_we=cpu_req_we, mem_addr=cpu_req_addr, mem_wdata=cpu_req_wdata.
  - At most one SRAM access per cycle; a display fetch always wins.
- CPU read response: the cycle after accept, cpu_resp_valid=1 for exactly one cycle with cpu_resp_rdata=mem_rdata. Writes produce no response.
- CPU address out of range (cpu_req_addr >= H_ACTIVE*V_ACTIVE):
  - Accepted normally, but mem_en stays 0.
  - A read still responds, with rdata=0.
- frame_done: 1 in the same cycle de_o outputs pixel H_ACTIVE*V_ACTIVE-1.
- en deassertion:
  - Counters and p_addr clear to 0 on the next edge.
  - Stage-1 outputs go to 0 one cycle later.
  - cpu_req_ready=1 continuously while en=0.
  - Re-enable starts at (0,0).
- Reset mid-operation: a pending read response is dropped (cpu_resp_valid=0); no partial SRAM write occurs after rst falls.
- When CPU and display address the same pixel in adjacent cycles, order is program order at the SRAM; no forwarding is required.

Test Plan:
1. Reset, then en=1 for one frame -> de_o high 400 cycles per line, for 300 lines. First de_o rises at cycle 1 after en; hs_o high 48 cycles starting at h_cnt=416 (+1 latency); vs_o high 4 lines starting at v_cnt=303.
2. Preload SRAM word k = k, scan one frame -> pixel k colour = k[23:0]; frame_done pulses once, on pixel 119999; second frame restarts at address 0.
3. CPU write (addr 5, 0x00AABBCC) asserted at h_cnt=10, v_cnt=0 -> ready stays 0 until h_cnt=400; SRAM written at that cycle; next frame pixel 5 = AA/BB/CC.
4. CPU read of addr 7 during blanking -> mem read the same cycle; cpu_resp_valid one cycle later with stored data. Read of addr 120000 -> mem_en=0, rdata=0.
5. en dropped at h_cnt=200, v_cnt=50 -> de_o/hs_o/vs_o = 0 within 1 cycle; cpu_req_ready=1. Re-enable -> first pixel fetched from address 0.
6. rst asserted mid-line during a pending CPU read -> all outputs 0 immediately, no response. Release -> timing restarts at (0,0).
